// File: rtl/uart_tx_framer_pkg.sv
// Shared definitions for the UART transmit/receive blocks: state encoding,
// payload width default and frame length.
package uart_tx_framer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    localparam int DATA_W_DEF = 32;

    // Start + payload + parity + stop.
    localparam int FRAME_BITS = DATA_W_DEF + 3;

    function automatic int frame_bits(input int data_w);
        return data_w + 3;
    endfunction

    // Width of a counter running 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts CLKS_PER_BIT clocks and flags the last clock of
// each serial bit. Wraps on its own at every bit boundary.
module uart_baud_tick
    import uart_tx_framer_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic Clk,
    input  logic Rst_n,
    input  logic i_restart,
    output logic o_bit_end
);

    localparam int CNT_W = cnt_width(CLKS_PER_BIT);

    logic [CNT_W-1:0] r_cnt;
    logic             w_last;

    assign w_last    = (r_cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign o_bit_end = w_last;

    always_ff @(posedge Clk or negedge Rst_n) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (!Rst_n) begin
            r_cnt <= '0;
        end else if (i_restart || w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmitter: start bit, DATA_W payload bits LSB first, even-parity bit,
// stop bit. All outputs are registered.
module uart_tx_framer
    import uart_tx_framer_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_W       = DATA_W_DEF
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Tx_Start,
    input  logic [DATA_W-1:0] Tx_data,
    output logic              Tx_Out,
    output logic              Tx_Busy,
    output logic              Tx_Done
);

    localparam int                BIT_W    = cnt_width(DATA_W);
    localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(DATA_W - 1);

    tx_state_e         r_state;
    tx_state_e         w_state_next;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] w_shift_next;
    logic [BIT_W-1:0]  r_bit_cnt;
    logic [BIT_W-1:0]  w_bit_cnt_next;
    logic              r_parity;
    logic              w_parity_next;
    logic              r_tx_out;
    logic              w_tx_out_next;
    logic              r_busy;
    logic              w_busy_next;
    logic              r_done;
    logic              w_done_next;
    logic              w_restart;
    logic              w_bit_end;

    // Holding the timer in reset while idle makes the start bit begin a full period.
    assign w_restart = (r_state == ST_IDLE);

    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_tick (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .i_restart (w_restart),
        .o_bit_end (w_bit_end)
    );

    always_comb begin
        // NOTE: every output gets a default first, so no path can infer a latch.
        w_state_next   = r_state;
        w_shift_next   = r_shift;
        w_bit_cnt_next = r_bit_cnt;
        w_parity_next  = r_parity;
        w_done_next    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (Tx_Start) begin
                    w_state_next   = ST_START;
                    w_shift_next   = Tx_data;
                    w_parity_next  = ^Tx_data;
                    w_bit_cnt_next = '0;
                end
            end
            ST_START: begin
                if (w_bit_end) begin
                    w_state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_bit_end) begin
                    w_shift_next = r_shift >> 1;
                    if (r_bit_cnt == LAST_BIT) begin
                        w_state_next   = ST_PARITY;
                        w_bit_cnt_next = '0;
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + BIT_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (w_bit_end) begin
                    w_state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                if (w_bit_end) begin
                    w_state_next = ST_IDLE;
                    w_done_next  = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Line level is decided from the next state so Tx_Out can be a plain flop.
    always_comb begin
        w_tx_out_next = 1'b1;
        case (w_state_next)
            ST_START:  w_tx_out_next = 1'b0;
            ST_DATA:   w_tx_out_next = w_shift_next[0];
            ST_PARITY: w_tx_out_next = w_parity_next;
            default:   w_tx_out_next = 1'b1;
        endcase
        w_busy_next = (w_state_next != ST_IDLE);
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state   <= ST_IDLE;
            // NOTE: the shift register is ordinary flops, so it is cleared by reset like the rest.
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_parity  <= 1'b0;
            r_tx_out  <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_shift   <= w_shift_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_parity  <= w_parity_next;
            r_tx_out  <= w_tx_out_next;
            r_busy    <= w_busy_next;
            r_done    <= w_done_next;
        end
    end

    assign Tx_Out  = r_tx_out;
    assign Tx_Busy = r_busy;
    assign Tx_Done = r_done;

endmodule
